pll_reset_sequencer: RTL and testbench

Sequences clock-generation bring-up and staged reset release for the SoC harness. It runs on the free-running board oscillator. It drives the PLL reset, qualifies PLL lock, and releases peripheral reset before core reset. It re-runs the sequence on lock loss, on an external reset button, or on a software/debug reset request, and records the cause. All outputs are registered in the `sys_clock` domain; consumers in the PLL domain synchronize them.

---
 rtl/pll_reset_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and staged reset release sequencer on the free-running board clock.
// Re-runs the sequence on lock loss, debounced button press or software request and records the cause.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_STABLE     = 256,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int HOLD_CYCLES     = 1024,
    parameter int STAGE_GAP       = 16,
    parameter int DEBOUNCE_CYCLES = 4096
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       ext_reset_req,
    input  logic       sw_reset_req,
    output logic       pll_rst,
    output logic       periph_reset,
    output logic       core_reset,
    output logic       reset_done,
    output logic [1:0] reset_cause,
    output logic [3:0] lock_retries
);

    localparam int CMAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CMAX_B = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CMAX   = (CMAX_A > CMAX_B) ? CMAX_A : CMAX_B;
    localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int SW     = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int DW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PLLRST,
        ST_LOCK,
        ST_HOLD,
        ST_PERIPH,
        ST_RUN
    } state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_EXT  = 2'd2;
    localparam logic [1:0] CAUSE_SW   = 2'd3;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause_nxt;
    logic          w_retry;
    logic [3:0]    r_retries;

    logic          r_lock_m, r_lock_s;
    logic          r_ext_m, r_ext_s;
    logic [DW-1:0] r_db_cnt;
    logic          r_ext_db, r_ext_db_d;
    logic          w_ext_rise;

    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_stable;

    logic          r_pll_rst, r_periph_rst, r_core_rst, r_done;

    // Two-flop synchronizers for the asynchronous lock and button inputs.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
            r_ext_m  <= 1'b0;
            r_ext_s  <= 1'b0;
        end else begin
            r_lock_m <= pll_locked;
            r_lock_s <= r_lock_m;
            r_ext_m  <= ext_reset_req;
            r_ext_s  <= r_ext_m;
        end
    end

    // The debounced level flips only after DEBOUNCE_CYCLES samples that all disagree with it.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_ext_db   <= 1'b0;
            r_ext_db_d <= 1'b0;
        end else begin
            r_ext_db_d <= r_ext_db;
            if (r_ext_s == r_ext_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_ext_db <= r_ext_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    assign w_ext_rise = r_ext_db & ~r_ext_db_d;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_state <= ST_PLLRST;
            r_cause <= CAUSE_POR;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_retry     = 1'b0;
        if (w_ext_rise && r_state != ST_PLLRST) begin
            w_state_nxt = ST_PLLRST;
            w_cause_nxt = CAUSE_EXT;
        end else if (!r_lock_s && (r_state inside {ST_HOLD, ST_PERIPH, ST_RUN})) begin
            w_state_nxt = ST_PLLRST;
            w_cause_nxt = CAUSE_LOCK;
        end else if (sw_reset_req && r_state == ST_RUN) begin
            // Software reset re-runs only the staged release; the PLL keeps running.
            w_state_nxt = ST_HOLD;
            w_cause_nxt = CAUSE_SW;
        end else begin
            case (r_state)
                ST_PLLRST: begin
                    if (!r_ext_db && r_cnt == PLL_LAST) w_state_nxt = ST_LOCK;
                end
                ST_LOCK: begin
                    if (r_lock_s && r_stable == STB_LAST) begin
                        w_state_nxt = ST_HOLD;
                    end else if (r_cnt == TO_LAST) begin
                        w_state_nxt = ST_PLLRST;
                        w_retry     = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) w_state_nxt = ST_PERIPH;
                end
                ST_PERIPH: begin
                    if (r_cnt == GAP_LAST) w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Shared phase counter; parked in RUN so it never wraps.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_PLLRST && r_ext_db) begin
            r_cnt <= '0;
        end else if (r_state != ST_RUN) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_stable <= '0;
        end else if (w_state_nxt != r_state || r_state != ST_LOCK || !r_lock_s) begin
            r_stable <= '0;
        end else begin
            r_stable <= r_stable + SW'(1);
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_retries <= '0;
        end else if (w_retry && r_retries != 4'hF) begin
            r_retries <= r_retries + 4'd1;
        end
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            r_pll_rst    <= 1'b1;
            r_periph_rst <= 1'b1;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_pll_rst    <= (w_state_nxt == ST_PLLRST);
            r_periph_rst <= (w_state_nxt inside {ST_PLLRST, ST_LOCK, ST_HOLD});
            r_core_rst   <= (w_state_nxt != ST_RUN);
            r_done       <= (w_state_nxt == ST_RUN);
        end
    end

    assign pll_rst      = r_pll_rst;
    assign periph_reset = r_periph_rst;
    assign core_reset   = r_core_rst;
    assign reset_done   = r_done;
    assign reset_cause  = r_cause;
    assign lock_retries = r_retries;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random stimulus, checked every cycle
// against a history-based reference model of the sequencing rules.
module tb_pll_reset_sequencer;

    localparam int PRC  = 4;
    localparam int LS   = 8;
    localparam int LT   = 64;
    localparam int HC   = 16;
    localparam int SG   = 4;
    localparam int DB   = 4;
    localparam int MAXC = 8192;

    logic       clk;
    logic       rst, pl, ex, sw;
    logic       pll_rst, periph_reset, core_reset, reset_done;
    logic [1:0] reset_cause;
    logic [3:0] lock_retries;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_STABLE    (LS),
        .LOCK_TIMEOUT   (LT),
        .HOLD_CYCLES    (HC),
        .STAGE_GAP      (SG),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .sys_clock    (clk),
        .reset        (rst),
        .pll_locked   (pl),
        .ext_reset_req(ex),
        .sw_reset_req (sw),
        .pll_rst      (pll_rst),
        .periph_reset (periph_reset),
        .core_reset   (core_reset),
        .reset_done   (reset_done),
        .reset_cause  (reset_cause),
        .lock_retries (lock_retries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int R       = 0;

    // Input history (value during cycle c) and derived synchronized/debounced histories.
    bit rst_h[MAXC], pl_h[MAXC], ex_h[MAXC], sw_h[MAXC];
    bit ls_h[MAXC], es_h[MAXC], db_h[MAXC];
    logic       o_pll[MAXC], o_per[MAXC], o_core[MAXC], o_done[MAXC];
    logic [1:0] o_cause[MAXC];
    logic [3:0] o_retry[MAXC];

    string m_ph = "";
    int    t_ent = 0;
    int    m_cause = 0;
    int    m_retry = 0;
    bit    m_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    function automatic bit hr(input int k);
        return (k < 0) ? 1'b1 : rst_h[k];
    endfunction

    function automatic bit ls_all_high(input int lo, input int hi);
        if (lo < 0) return 1'b0;
        for (int k = lo; k <= hi; k++) if (!ls_h[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit db_all_low(input int lo, input int hi);
        if (lo < 0) return 1'b0;
        for (int k = lo; k <= hi; k++) if (db_h[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model across the edge that ends cycle c.
    task automatic model_step(input int c);
        int    n = c + 1;
        int    el;
        bit    flip, rise;
        string nx;
        if (hr(c) || hr(c - 1)) begin
            ls_h[n] = 1'b0;
            es_h[n] = 1'b0;
        end else begin
            ls_h[n] = pl_h[c - 1];
            es_h[n] = ex_h[c - 1];
        end
        if (hr(c)) begin
            db_h[n] = 1'b0;
        end else begin
            flip = 1'b1;
            for (int k = c - DB + 1; k <= c; k++) if (k < 0 || es_h[k] == db_h[c]) flip = 1'b0;
            db_h[n] = flip ? !db_h[c] : db_h[c];
        end
        if (hr(c)) begin
            m_ph = "PLLRST"; t_ent = n; m_cause = 0; m_retry = 0; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        rise = (c > 0) && db_h[c] && !db_h[c - 1];
        el   = c - t_ent;
        nx   = m_ph;
        if (rise && m_ph != "PLLRST") begin
            nx = "PLLRST"; m_cause = 2;
        end else if (!ls_h[c] && (m_ph == "HOLD" || m_ph == "PERIPH" || m_ph == "RUN")) begin
            nx = "PLLRST"; m_cause = 1;
        end else if (sw_h[c] && m_ph == "RUN") begin
            nx = "HOLD"; m_cause = 3;
        end else if (m_ph == "PLLRST") begin
            if (c - PRC + 1 >= t_ent && db_all_low(c - PRC + 1, c)) nx = "LOCK";
        end else if (m_ph == "LOCK") begin
            if (c - LS + 1 >= t_ent && ls_all_high(c - LS + 1, c)) nx = "HOLD";
            else if (el == LT - 1) begin
                nx = "PLLRST";
                if (m_retry < 15) m_retry++;
            end
        end else if (m_ph == "HOLD") begin
            if (el == HC - 1) nx = "PERIPH";
        end else if (m_ph == "PERIPH") begin
            if (el == SG - 1) nx = "RUN";
        end
        if (nx != m_ph) begin
            m_ph  = nx;
            t_ent = n;
        end
    endtask

    task automatic tick();
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget cycle=%0d observed=overrun expected=<%0d", cyc, MAXC - 2);
            $fatal(1, "cycle budget exhausted");
        end
        rst_h[cyc] = rst; pl_h[cyc] = pl; ex_h[cyc] = ex; sw_h[cyc] = sw;
        @(posedge clk);
        model_step(cyc);
        cyc++;
        #1;
        o_pll[cyc] = pll_rst; o_per[cyc] = periph_reset; o_core[cyc] = core_reset;
        o_done[cyc] = reset_done; o_cause[cyc] = reset_cause; o_retry[cyc] = lock_retries;
        if (m_valid) begin
            chk("pll_rst",      pll_rst,      (m_ph == "PLLRST"));
            chk("periph_reset", periph_reset, (m_ph == "PLLRST" || m_ph == "LOCK" || m_ph == "HOLD"));
            chk("core_reset",   core_reset,   (m_ph != "RUN"));
            chk("reset_done",   reset_done,   (m_ph == "RUN"));
            chk("reset_cause",  reset_cause,  m_cause);
            chk("lock_retries", lock_retries, m_retry);
        end
        sw = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        R = cyc;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (reset_done !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        chk("wait_done", reset_done, 1);
    endtask

    initial begin
        int p, e, f, s, k;
        rst = 1'b1; pl = 1'b1; ex = 1'b0; sw = 1'b0;

        // Nominal bring-up with lock high throughout.
        do_reset(3);
        chk("por_pll_rst", o_pll[R], 1);
        chk("por_done", o_done[R], 0);
        run(40);
        chk("bu_pll_hi",  o_pll[R + 3], 1);
        chk("bu_pll_lo",  o_pll[R + 4], 0);
        chk("bu_per_hi",  o_per[R + 27], 1);
        chk("bu_per_lo",  o_per[R + 28], 0);
        chk("bu_core_hi", o_core[R + 31], 1);
        chk("bu_core_lo", o_core[R + 32], 0);
        chk("bu_done",    o_done[R + 32], 1);
        chk("bu_cause",   o_cause[R + 32], 0);

        // Short lock drop in RUN.
        p = cyc; pl = 1'b0;
        run($urandom_range(1, 3));
        pl = 1'b1;
        run(50);
        chk("ll_done_hold", o_done[p + 2], 1);
        chk("ll_done_fall", o_done[p + 3], 0);
        chk("ll_pll",       o_pll[p + 3], 1);
        chk("ll_cause",     o_cause[p + 3], 1);

        // Button glitch shorter than the debounce window.
        ex = 1'b1;
        run($urandom_range(1, 3));
        ex = 1'b0;
        run(20);
        chk("glitch_done",  o_done[cyc], 1);
        chk("glitch_cause", o_cause[cyc], 1);

        // Long button press.
        e = cyc; ex = 1'b1;
        run(50);
        ex = 1'b0; f = cyc;
        run(60);
        chk("ext_pll_pre",  o_pll[e + 6], 0);
        chk("ext_pll",      o_pll[e + 7], 1);
        chk("ext_cause",    o_cause[e + 7], 2);
        chk("ext_held",     o_pll[f + 9], 1);
        chk("ext_release",  o_pll[f + 10], 0);
        chk("ext_run",      o_done[f + 38], 1);

        // Software reset in RUN, then a request landing in PERIPH.
        s = cyc; sw = 1'b1;
        tick();
        run(17);
        sw = 1'b1;
        run(10);
        chk("sw_core",    o_core[s + 1], 1);
        chk("sw_per",     o_per[s + 1], 1);
        chk("sw_pll",     o_pll[s + 1], 0);
        chk("sw_cause",   o_cause[s + 1], 3);
        chk("sw_notrun",  o_done[s + 20], 0);
        chk("sw_run",     o_done[s + 21], 1);

        // Software request coinciding with synchronized lock loss.
        p = cyc; pl = 1'b0;
        tick();
        pl = 1'b1;
        tick();
        sw = 1'b1;
        tick();
        run(45);
        chk("swll_pll",   o_pll[p + 3], 1);
        chk("swll_cause", o_cause[p + 3], 1);

        // Reset asserted while in PERIPH.
        s = cyc; sw = 1'b1;
        tick();
        run(17);
        chk("pr_in_periph", o_per[cyc], 0);
        do_reset(1);
        chk("pr_pll",   o_pll[R], 1);
        chk("pr_per",   o_per[R], 1);
        chk("pr_core",  o_core[R], 1);
        chk("pr_done",  o_done[R], 0);
        chk("pr_cause", o_cause[R], 0);
        run(40);

        // Lock absent for 200 cycles: retries then release.
        pl = 1'b0;
        do_reset(2);
        run(200);
        pl = 1'b1;
        wait_done(200);
        chk("to_pll_lo",   o_pll[R + 67], 0);
        chk("to_pll_hi",   o_pll[R + 68], 1);
        chk("to_retries",  lock_retries, 3);

        // One-cycle lock glitch at stable count 7.
        do_reset(2);
        run(9);
        pl = 1'b0;
        tick();
        pl = 1'b1;
        run(40);
        chk("gl_per_nom",  o_per[R + 28], 1);
        chk("gl_per_hi",   o_per[R + 35], 1);
        chk("gl_per_lo",   o_per[R + 36], 0);

        // Retry counter saturation.
        pl = 1'b0;
        do_reset(2);
        run(1200);
        chk("sat_retries", lock_retries, 15);
        pl = 1'b1;
        wait_done(200);

        // Random mix of lock glitches, button presses, software requests and resets.
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: begin pl = 1'b0; run($urandom_range(1, 3)); pl = 1'b1; end
                1: begin ex = 1'b1; run($urandom_range(1, 10)); ex = 1'b0; end
                2: sw = 1'b1;
                3: if ($urandom_range(0, 3) == 0) do_reset(1);
                default: ;
            endcase
            run($urandom_range(5, 60));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
